// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the iterative multiply/divide unit
package muldiv_pkg;
  localparam int XLEN = 32;
  localparam int STEPS = 32;
  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV = 3'd2;
  localparam logic [2:0] OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;
endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement negation
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  assign y = en ? -x : x;
endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative 32-step multiply/divide unit owning HI/LO, stalls upstream while busy
module exe_muldiv
  import muldiv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            done
);
  state_t state;
  logic [4:0] cnt;
  logic [63:0] acc, acc_next, p_fix;
  logic [31:0] m, a_orig, mag_a, mag_b, q_fix, r_fix, rem_sub;
  logic is_div, sq, sr, div0, sgn, ge;
  logic [32:0] sum, t;
  assign sgn = ~op[0];
  muldiv_negate #(.W(32)) u_na (.en(sgn & a[31]), .x(a), .y(mag_a));
  muldiv_negate #(.W(32)) u_nb (.en(sgn & b[31]), .x(b), .y(mag_b));
  muldiv_negate #(.W(64)) u_np (.en(sq), .x(acc), .y(p_fix));
  muldiv_negate #(.W(32)) u_nq (.en(sq), .x(acc[31:0]), .y(q_fix));
  muldiv_negate #(.W(32)) u_nr (.en(sr), .x(acc[63:32]), .y(r_fix));
  // acc holds {product_hi, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    sum = {1'b0, acc[63:32]} + {1'b0, m};
    t = acc[63:31];
    ge = t >= {1'b0, m};
    rem_sub = t[31:0] - m;
    acc_next = is_div ? {ge ? rem_sub : t[31:0], acc[30:0], ge}
                      : (acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]});
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      stall <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      acc <= '0;
      m <= '0;
      a_orig <= '0;
      is_div <= 1'b0;
      sq <= 1'b0;
      sr <= 1'b0;
      div0 <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (op_valid) begin
          if (op <= OP_DIVU) begin
            state <= CALC;
            stall <= 1'b1;
            cnt <= '0;
            is_div <= op[1];
            sq <= sgn & (a[31] ^ b[31]);
            sr <= sgn & a[31];
            div0 <= b == '0;
            a_orig <= a;
            m <= op[1] ? mag_b : mag_a;
            acc <= {32'b0, op[1] ? mag_a : mag_b};
          end else if (op == OP_MTHI) hi <= a;
          else if (op == OP_MTLO) lo <= a;
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(STEPS - 1)) begin
            state <= FIX;
            done <= 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          stall <= 1'b0;
          hi <= !is_div ? p_fix[63:32] : (div0 ? a_orig : r_fix);
          lo <= !is_div ? p_fix[31:0] : (div0 ? '1 : q_fix);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: table-driven directed checks of exe_muldiv plus reset/MTHI/MTLO sequences
module tb_exe_muldiv;
  import muldiv_pkg::*;
  logic clock = 1'b0, reset = 1'b1, op_valid = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic stall, done;
  logic [31:0] hi, lo;
  int checks = 0, fails = 0;
  typedef struct {
    string name;
    logic [2:0] op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t v[11];
  always #5 clock = ~clock;
  exe_muldiv dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .stall(stall), .hi(hi), .lo(lo), .done(done)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // launch one op, then count stall cycles and locate the done pulse; optional MTLO poke mid-run
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit inject, output int sc, output int dc, output int dpos);
    @(negedge clock);
    op_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    op_valid = 1'b0; op = '0; a = '0; b = '0;
    sc = 0; dc = 0; dpos = 0;
    for (int i = 0; i < 40; i++) begin
      if (!stall) break;
      sc++;
      if (done) begin dc++; dpos = sc; end
      if (inject && sc == 5) begin op_valid = 1'b1; op = OP_MTLO; a = 32'hBAD0_BAD0; end
      else begin op_valid = 1'b0; op = '0; a = '0; end
      @(negedge clock);
    end
    op_valid = 1'b0; op = '0; a = '0;
  endtask
  initial begin
    int sc, dc, dpos;
    v[0]  = '{"mult_neg3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    v[1]  = '{"multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    v[2]  = '{"div_neg7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[3]  = '{"divu_100_7",    OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
    v[4]  = '{"divu_by0",      OP_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF};
    v[5]  = '{"div_ovf",       OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
    v[6]  = '{"mult_min_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    v[7]  = '{"div_7_neg2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    v[8]  = '{"div_neg5_by0",  OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
    v[9]  = '{"multu_shift",   OP_MULTU, 32'h1234_5678, 32'h10,       32'h1,         32'h2345_6780};
    v[10] = '{"mult_pos_neg",  OP_MULT,  32'd1000,      32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_F830};
    repeat (2) @(negedge clock);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, 1'b0, sc, dc, dpos);
      check({v[i].name, "_stall_cycles"}, 64'(sc), 64'd33);
      check({v[i].name, "_done_count"}, 64'(dc), 64'd1);
      check({v[i].name, "_done_pos"}, 64'(dpos), 64'd33);
      check({v[i].name, "_hi"}, 64'(hi), 64'(v[i].hi));
      check({v[i].name, "_lo"}, 64'(lo), 64'(v[i].lo));
    end
    @(negedge clock);
    op_valid = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    check("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
    check("mthi_lo_kept", 64'(lo), 64'(v[10].lo));
    check("mthi_stall", 64'(stall), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    @(negedge clock);
    op = OP_MTLO; a = 32'h0BAD_F00D;
    @(negedge clock);
    op_valid = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h0BAD_F00D);
    check("mtlo_stall", 64'(stall), 64'd0);
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b1, sc, dc, dpos);
    check("mtlo_in_calc_cycles", 64'(sc), 64'd33);
    check("mtlo_in_calc_lo", 64'(lo), 64'd14);
    check("mtlo_in_calc_hi", 64'(hi), 64'd2);
    @(negedge clock);
    op_valid = 1'b1; op = OP_MULT; a = 32'hFFFF_FFFD; b = 32'd7;
    @(negedge clock);
    op_valid = 1'b0;
    check("reset_seq_busy", 64'(stall), 64'd1);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("reset_mid_stall", 64'(stall), 64'd0);
    check("reset_mid_done", 64'(done), 64'd0);
    check("reset_mid_hilo", {hi, lo}, 64'd0);
    repeat (30) @(negedge clock);
    check("reset_no_late_result", {hi, lo}, 64'd0);
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, sc, dc, dpos);
    check("post_reset_cycles", 64'(sc), 64'd33);
    check("post_reset_done", 64'(dc), 64'd1);
    check("post_reset_hilo", {hi, lo}, {32'd2, 32'd14});
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Iterative multiply/divide unit in the EXE stage of the 5-stage pipeline, fed by the ID/EXE pipeline register. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations and owns the architectural HI/LO registers. While a 32-step operation runs, it drives a stall back toward IF/ID and ID/EXE so that upstream stages hold. It is the consuming end of the issue path: ID/EXE launches an operation, and this block accepts it and applies back-pressure.

## Interface
Parameters:
- none (width fixed at 32; constants live in the package)

Ports:
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock
- op_valid  in  1  EXE holds a muldiv-class instruction this cycle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no-op)
- a  in  32  rs operand (multiplicand / dividend / MTHI/MTLO source)
- b  in  32  rt operand (multiplier / divisor)
- stall  out  1  upstream hold request; registered
- hi  out  32  HI register; feeds MFHI datapath
- lo  out  32  LO register; feeds MFLO datapath
- done  out  1  one-cycle pulse in the cycle HI/LO receive a mul/div result

## Operation
- Reset values: state IDLE, stall 0, done 0, hi 0, lo 0, step counter 0, internal accumulators 0.
- States:
  - IDLE: accepts operations.
  - CALC: 32 iterations, counter 0..31.
  - FIX: applies sign correction and writes HI/LO.
- IDLE, op_valid with op 0–3: latch operands. For signed ops, latch the magnitudes and record the result signs.
  - mul result sign = sign(a) XOR sign(b).
  - quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Next state CALC, counter 0.
- IDLE, op_valid with op 4/5: write hi (or lo) = a at the next edge. No state change, no stall, no done.
- IDLE, op 6/7 or op_valid=0: nothing happens.
- CALC, multiply: shift-add, one multiplier bit per cycle. 64-bit unsigned product of the magnitudes.
- CALC, divide: restoring division, one quotient bit per cycle. Uses a 33-bit partial-remainder subtract.
- After counter 31, next state FIX.
- FIX actions:
  - Negate (two's complement) the result parts whose recorded sign is 1.
  - mul: hi = product[63:32], lo = product[31:0].
  - div: lo = quotient, hi = remainder.
  - done = 1 for this cycle; next state IDLE.
- Divide by zero (b == 0): decided result is lo = 32'hFFFF_FFFF, hi = a (original, unmodified). Latency is unchanged.
  - Signed overflow case 0x8000_0000 / -1: lo = 0x8000_0000, hi = 0 (natural result of the magnitude algorithm plus sign fix).
- op_valid while stall=1 is ignored. Upstream is held, so the same instruction is not re-accepted.
- Reset in any state: immediate return to IDLE with all reset values. The in-flight result is discarded and HI/LO are cleared.

## Timing
- Accept edge E0 (state IDLE, op_valid, op 0–3).
- stall = 1 from after E0 through the FIX cycle: 33 cycles. stall = 0 after edge E0+33.
- done is high in the FIX cycle (between E0+32 and E0+33). hi/lo hold new values after edge E0+33.
- MTHI/MTLO: 1-cycle latency; hi/lo update on the accept edge.
- hi/lo are stable outside update edges. MFHI in the cycle after stall falls reads the new value.
- A back-to-back mul/div may be accepted on edge E0+33, the first IDLE cycle.

## Structure
- Shared package `muldiv_pkg`:
  - op encoding constants (OP_MULT..OP_MTLO)
  - state enum IDLE/CALC/FIX
  - XLEN = 32, STEPS = 32
- One sub-module is natural: `muldiv_negate`, a combinational conditional two's-complement of 32/64 bits. It is used for operand magnitude and result fix.
- Everything else stays in `exe_muldiv`; expected size is 150–250 lines.

## Test plan
- MULT a=-3 (0xFFFF_FFFD), b=7 -> stall high 33 cycles; done pulse; hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001 after E0+33.
- DIV a=-7, b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> lo=0xFFFF_FFFF, hi=0x1234, same 33-cycle stall.
- MTHI a=0xDEAD_BEEF in IDLE -> hi=0xDEAD_BEEF next edge, stall stays 0, done stays 0. MTLO issued during CALC is ignored.
- Start MULT, assert reset at counter 10 -> next edge: stall 0, hi=lo=0, state IDLE. A new DIVU after reset completes normally.
